// File: rtl/sobel_win_ctrl.sv
// 3x3 window sequencer for the Sobel datapath: two line buffers, raster counters, window strobes.
// Optional build macro SOBEL_BORDER_PAD_EN adds pad_valid for pixels that produce no window.
module sobel_win_ctrl #(
    parameter int IMG_W = 100,
    parameter int IMG_H = 100,
    parameter int PIX_W = 8
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               pi_flag,
    input  logic [PIX_W-1:0]   pi_data,
    output logic               win_valid,
    output logic [9*PIX_W-1:0] win_data,
    output logic [15:0]        win_row,
    output logic [15:0]        win_col,
    output logic               frame_done,
`ifdef SOBEL_BORDER_PAD_EN
    output logic               pad_valid,
`endif
    output logic               busy
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

    logic [CW-1:0]      col_cnt;
    logic [RW-1:0]      row_cnt;
    logic [PIX_W-1:0]   lb0 [IMG_W];
    logic [PIX_W-1:0]   lb1 [IMG_W];
    logic [3*PIX_W-1:0] col_a;
    logic [3*PIX_W-1:0] col_b;
    logic [PIX_W-1:0]   top;
    logic [PIX_W-1:0]   mid;
    logic [3*PIX_W-1:0] col_new;
    logic [9*PIX_W-1:0] next_win;
    logic               interior;
    logic               last_col;
    logic               last_pix;

    // Columns are stored {top, mid, bottom}; col_a is the oldest, the incoming column is the newest.
    always_comb begin
        top      = lb0[col_cnt];
        mid      = lb1[col_cnt];
        col_new  = {top, mid, pi_data};
        next_win = {col_a[3*PIX_W-1:2*PIX_W], col_b[3*PIX_W-1:2*PIX_W], top,
                    col_a[2*PIX_W-1:PIX_W],   col_b[2*PIX_W-1:PIX_W],   mid,
                    col_a[PIX_W-1:0],         col_b[PIX_W-1:0],         pi_data};
        interior = (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
        last_col = (col_cnt == LAST_COL);
        last_pix = last_col && (row_cnt == LAST_ROW);
    end

    // Line buffers are left uninitialised; the interior gate never reads rows unwritten this frame.
    always_ff @(posedge sys_clk) begin
        if (pi_flag && !sys_rst) begin
            lb0[col_cnt] <= mid;
            lb1[col_cnt] <= pi_data;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            col_a      <= '0;
            col_b      <= '0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
`ifdef SOBEL_BORDER_PAD_EN
            pad_valid  <= 1'b0;
`endif
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
`ifdef SOBEL_BORDER_PAD_EN
            pad_valid  <= 1'b0;
`endif
            if (pi_flag) begin
                col_a <= col_b;
                col_b <= col_new;
                if (last_col) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
                if (interior) begin
                    win_valid <= 1'b1;
                    win_data  <= next_win;
                    win_row   <= 16'(row_cnt) - 16'd1;
                    win_col   <= 16'(col_cnt) - 16'd1;
                end
`ifdef SOBEL_BORDER_PAD_EN
                pad_valid <= !interior;
`endif
                if (last_pix) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                end else if (row_cnt == '0 && col_cnt == '0) begin
                    busy <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_win_ctrl.sv
// Directed bench for sobel_win_ctrl: a 4x4 instance for hand-checked frames and a default 100x100 instance.
// Pad strobe checks compile in when SOBEL_BORDER_PAD_EN is defined.
module tb_sobel_win_ctrl;

    logic        clk = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;

    logic        rst4, flag4;
    logic [7:0]  data4;
    logic        wv4, fd4, busy4;
    logic [71:0] wd4;
    logic [15:0] wr4, wc4;
    logic        pad4;

    logic        rst100, flag100;
    logic [7:0]  data100;
    logic        wv100, fd100, busy100;
    logic [71:0] wd100;
    logic [15:0] wr100, wc100;
    logic        pad100;

    logic [7:0]  img4 [4][4];
    logic [7:0]  img100 [10000];
    logic [71:0] exp_d4;
    logic [15:0] exp_r4, exp_c4;

    always #5 clk = ~clk;

    sobel_win_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) dut4 (
        .sys_clk(clk), .sys_rst(rst4), .pi_flag(flag4), .pi_data(data4),
        .win_valid(wv4), .win_data(wd4), .win_row(wr4), .win_col(wc4),
        .frame_done(fd4),
`ifdef SOBEL_BORDER_PAD_EN
        .pad_valid(pad4),
`endif
        .busy(busy4)
    );

    sobel_win_ctrl dut100 (
        .sys_clk(clk), .sys_rst(rst100), .pi_flag(flag100), .pi_data(data100),
        .win_valid(wv100), .win_data(wd100), .win_row(wr100), .win_col(wc100),
        .frame_done(fd100),
`ifdef SOBEL_BORDER_PAD_EN
        .pad_valid(pad100),
`endif
        .busy(busy100)
    );

`ifndef SOBEL_BORDER_PAD_EN
    assign pad4   = 1'b0;
    assign pad100 = 1'b0;
`endif

    task automatic cyc4(input logic f, input logic [7:0] d, input logic r);
        @(negedge clk);
        flag4 = f; data4 = d; rst4 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic cyc100(input logic f, input logic [7:0] d, input logic r);
        @(negedge clk);
        flag100 = f; data100 = d; rst100 = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] golden4(input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], img4[r-2+i][c-2+j]};
        return w;
    endfunction

    function automatic logic [71:0] golden100(input int r, input int c);
        logic [71:0] w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w = {w[63:0], img100[(r-2+i)*100 + c-2+j]};
        return w;
    endfunction

    // Sends one full 4x4 frame back-to-back and checks every output cycle against the golden model.
    task automatic frame4(input logic [7:0] base, output int nwin, output int ndone, output int npad,
                          output logic [71:0] first_win, output logic [71:0] last_win,
                          output logic [15:0] frow, output logic [15:0] fcol);
        int r, c;
        logic ev;
        nwin = 0; ndone = 0; npad = 0;
        first_win = '0; last_win = '0; frow = '0; fcol = '0;
        for (int k = 0; k < 16; k++) begin
            r = k / 4; c = k % 4;
            img4[r][c] = base + 8'(k);
            cyc4(1'b1, base + 8'(k), 1'b0);
            ev = (r >= 2 && c >= 2);
            if (ev) begin
                exp_d4 = golden4(r, c);
                exp_r4 = 16'(r - 1);
                exp_c4 = 16'(c - 1);
            end
            n_vec++;
            if (wv4 !== ev) begin n_err++; $display("[TB] FAIL win_valid4 px%0d: got %b expected %b", k, wv4, ev); end
            n_vec++;
            if (wd4 !== exp_d4) begin n_err++; $display("[TB] FAIL win_data4 px%0d: got %h expected %h", k, wd4, exp_d4); end
            n_vec++;
            if (wr4 !== exp_r4 || wc4 !== exp_c4) begin
                n_err++; $display("[TB] FAIL win_pos4 px%0d: got %0d,%0d expected %0d,%0d", k, wr4, wc4, exp_r4, exp_c4);
            end
            n_vec++;
            if (fd4 !== (k == 15)) begin n_err++; $display("[TB] FAIL frame_done4 px%0d: got %b expected %b", k, fd4, (k == 15)); end
            n_vec++;
            if (busy4 !== (k != 15)) begin n_err++; $display("[TB] FAIL busy4 px%0d: got %b expected %b", k, busy4, (k != 15)); end
`ifdef SOBEL_BORDER_PAD_EN
            n_vec++;
            if (pad4 !== !ev) begin n_err++; $display("[TB] FAIL pad_valid4 px%0d: got %b expected %b", k, pad4, !ev); end
            if (pad4 === 1'b1) npad++;
`endif
            if (wv4 === 1'b1) begin
                nwin++;
                if (nwin == 1) begin first_win = wd4; frow = wr4; fcol = wc4; end
                last_win = wd4;
            end
            if (fd4 === 1'b1) ndone++;
        end
        cyc4(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (wv4 !== 1'b0 || fd4 !== 1'b0 || busy4 !== 1'b0 || pad4 !== 1'b0) begin
            n_err++; $display("[TB] FAIL idle4: got v=%b d=%b b=%b p=%b expected all 0", wv4, fd4, busy4, pad4);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cyc4(i[0] ? 1'b0 : 1'b1, 8'hFF, 1'b1);
            n_vec++;
            if ({wv4, fd4, busy4, pad4} !== 4'b0 || wd4 !== 72'h0 || wr4 !== 16'h0 || wc4 !== 16'h0) begin
                n_err++;
                $display("[TB] FAIL reset cyc%0d: got v=%b d=%b b=%b p=%b data=%h row=%0d col=%0d expected all 0",
                         i, wv4, fd4, busy4, pad4, wd4, wr4, wc4);
            end
        end
        exp_d4 = '0; exp_r4 = '0; exp_c4 = '0;
        cyc4(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_basic_4x4();
        int nw, nd, np;
        logic [71:0] fw, lw;
        logic [15:0] fr, fc;
        frame4(8'h00, nw, nd, np, fw, lw, fr, fc);
        n_vec++;
        if (fw !== 72'h00_01_02_04_05_06_08_09_0A) begin n_err++; $display("[TB] FAIL first_win: got %h expected 000102040506080 90a", fw); end
        n_vec++;
        if (fr !== 16'd1 || fc !== 16'd1) begin n_err++; $display("[TB] FAIL first_pos: got %0d,%0d expected 1,1", fr, fc); end
        n_vec++;
        if (lw !== 72'h05_06_07_09_0A_0B_0D_0E_0F) begin n_err++; $display("[TB] FAIL last_win: got %h expected 0506070 90a0b0d0e0f", lw); end
        n_vec++;
        if (nw !== 4) begin n_err++; $display("[TB] FAIL win_count4: got %0d expected 4", nw); end
        n_vec++;
        if (nd !== 1) begin n_err++; $display("[TB] FAIL done_count4: got %0d expected 1", nd); end
`ifdef SOBEL_BORDER_PAD_EN
        n_vec++;
        if (np !== 12) begin n_err++; $display("[TB] FAIL pad_count4: got %0d expected 12", np); end
`endif
    endtask

    task automatic test_back_to_back();
        int nw, nd, np;
        logic [71:0] fw, lw;
        logic [15:0] fr, fc;
        frame4(8'h20, nw, nd, np, fw, lw, fr, fc);
        frame4(8'h30, nw, nd, np, fw, lw, fr, fc);
        n_vec++;
        if (fw !== 72'h30_31_32_34_35_36_38_39_3A) begin n_err++; $display("[TB] FAIL b2b_first_win: got %h expected 303132343536383 93a", fw); end
        n_vec++;
        if (fr !== 16'd1 || fc !== 16'd1) begin n_err++; $display("[TB] FAIL b2b_first_pos: got %0d,%0d expected 1,1", fr, fc); end
        n_vec++;
        if (nw !== 4 || nd !== 1) begin n_err++; $display("[TB] FAIL b2b_counts: got %0d,%0d expected 4,1", nw, nd); end
    endtask

    task automatic test_mid_reset();
        int nw, nd, np;
        logic [71:0] fw, lw;
        logic [15:0] fr, fc;
        for (int k = 0; k < 8; k++) begin
            cyc4(1'b1, 8'h40 + 8'(k), 1'b0);
            n_vec++;
            if (wv4 !== 1'b0) begin n_err++; $display("[TB] FAIL partial_valid px%0d: got %b expected 0", k, wv4); end
        end
        cyc4(1'b1, 8'hEE, 1'b1);
        n_vec++;
        if ({wv4, fd4, busy4, pad4} !== 4'b0 || wd4 !== 72'h0 || wr4 !== 16'h0 || wc4 !== 16'h0) begin
            n_err++; $display("[TB] FAIL midreset_clear: got v=%b b=%b data=%h row=%0d col=%0d expected all 0", wv4, busy4, wd4, wr4, wc4);
        end
        exp_d4 = '0; exp_r4 = '0; exp_c4 = '0;
        frame4(8'h10, nw, nd, np, fw, lw, fr, fc);
        n_vec++;
        if (fw !== 72'h10_11_12_14_15_16_18_19_1A) begin n_err++; $display("[TB] FAIL midreset_first_win: got %h expected 101112141516181 91a", fw); end
        n_vec++;
        if (nw !== 4 || nd !== 1) begin n_err++; $display("[TB] FAIL midreset_counts: got %0d,%0d expected 4,1", nw, nd); end
    endtask

    // Full default frame with random idle gaps; every window is compared with a golden extraction.
    task automatic test_frame_100();
        int nwin = 0, ndone = 0, r, c, gap;
        logic ev;
        logic [7:0] d;
        cyc100(1'b0, 8'h00, 1'b1);
        cyc100(1'b1, 8'h55, 1'b1);
        for (int k = 0; k < 10000; k++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                cyc100(1'b0, 8'h00, 1'b0);
                n_vec++;
                if (wv100 !== 1'b0 || fd100 !== 1'b0 || busy100 !== (k > 0) || pad100 !== 1'b0) begin
                    n_err++; $display("[TB] FAIL gap100 px%0d: got v=%b d=%b b=%b expected 0,0,%b", k, wv100, fd100, busy100, (k > 0));
                end
            end
            r = k / 100; c = k % 100;
            d = 8'($urandom);
            img100[k] = d;
            cyc100(1'b1, d, 1'b0);
            ev = (r >= 2 && c >= 2);
            n_vec++;
            if (wv100 !== ev) begin n_err++; $display("[TB] FAIL win_valid100 r%0d c%0d: got %b expected %b", r, c, wv100, ev); end
            if (ev) begin
                n_vec++;
                if (wd100 !== golden100(r, c) || wr100 !== 16'(r - 1) || wc100 !== 16'(c - 1)) begin
                    n_err++;
                    $display("[TB] FAIL window100 r%0d c%0d: got %h @%0d,%0d expected %h @%0d,%0d",
                             r, c, wd100, wr100, wc100, golden100(r, c), r - 1, c - 1);
                end
            end
            n_vec++;
            if (fd100 !== (k == 9999) || busy100 !== (k != 9999)) begin
                n_err++; $display("[TB] FAIL done_busy100 px%0d: got %b,%b expected %b,%b", k, fd100, busy100, (k == 9999), (k != 9999));
            end
`ifdef SOBEL_BORDER_PAD_EN
            n_vec++;
            if (pad100 !== !ev) begin n_err++; $display("[TB] FAIL pad_valid100 px%0d: got %b expected %b", k, pad100, !ev); end
`endif
            if (wv100 === 1'b1) nwin++;
            if (fd100 === 1'b1) ndone++;
        end
        cyc100(1'b0, 8'h00, 1'b0);
        n_vec++;
        if (nwin !== 9604) begin n_err++; $display("[TB] FAIL win_count100: got %0d expected 9604", nwin); end
        n_vec++;
        if (ndone !== 1) begin n_err++; $display("[TB] FAIL done_count100: got %0d expected 1", ndone); end
    endtask

    initial begin
        rst4 = 1'b1; flag4 = 1'b0; data4 = '0;
        rst100 = 1'b1; flag100 = 1'b0; data100 = '0;
        exp_d4 = '0; exp_r4 = '0; exp_c4 = '0;
        test_reset();
        test_basic_4x4();
        test_back_to_back();
        test_mid_reset();
        test_frame_100();
        test_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
